// File: rtl/gaus_read_sequencer.sv
// gaus_read_sequencer
//    Read scheduler for the Gaussian line-buffer datapath. Issues bursts of
//    BEATS word reads across [STARTADDRESS, ENDADDRESS], pops the line buffer
//    as each word returns, offers a window-valid handshake once a burst has
//    fully landed, then idles PAUSE cycles before the next burst.
//
// Ports
//    clk, reset     sole clock, synchronous active-high reset
//    start          one-cycle frame start, honoured only in IDLE
//    readAddress    word address of the current request
//    read           read request strobe (accepted when waitRequest=0)
//    waitRequest    memory stall
//    readDataValid  returned word present on the memory bus
//    popBufferEn    shift strobe to the buffer block (combinational)
//    windowValid    burst captured, held until windowReady
//    windowReady    downstream accepts the window
//    busy           high in every state except IDLE
//    done           one-cycle pulse on frame completion
//    abort          (GAUS_SEQ_ABORT_EN only) cancel remaining requests
//
// Build option
//    GAUS_SEQ_ABORT_EN  adds the abort input and its FSM paths.
module gaus_read_sequencer #(
   parameter int unsigned STARTADDRESS = 0,
   parameter int unsigned ENDADDRESS   = 2097151,
   parameter int unsigned BEATS        = 4,
   parameter int unsigned PAUSE        = 1,
   parameter int unsigned ADDRW        = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [ADDRW-1:0] readAddress,
   output logic             read,
   input  logic             waitRequest,
   input  logic             readDataValid,
   output logic             popBufferEn,
   output logic             windowValid,
   input  logic             windowReady,
   output logic             busy,
   output logic             done
`ifdef GAUS_SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);

   localparam int unsigned CW = $clog2(BEATS + 1);
   localparam int unsigned GW = (PAUSE > 1) ? $clog2(PAUSE) : 1;

   localparam logic [ADDRW-1:0] START_A  = ADDRW'(STARTADDRESS);
   localparam logic [ADDRW-1:0] END_A    = ADDRW'(ENDADDRESS);
   localparam logic [CW-1:0]    BEATS_C  = CW'(BEATS);
   localparam logic [CW-1:0]    REQ_LAST = CW'(BEATS - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((PAUSE > 0) ? PAUSE - 1 : 0);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, HOLD, GAP, FIN} state_t;

   state_t           state;
   logic [ADDRW-1:0] addr;
   logic [CW-1:0]    reqCount;
   logic [CW-1:0]    rspCount;
   logic [CW-1:0]    rspNext;
   logic [GW-1:0]    gapCount;
   logic             atEnd;     // last accepted request was ENDADDRESS
   logic             readReg;
   logic             accept;
   logic             rspIn;
`ifdef GAUS_SEQ_ABORT_EN
   logic             aborting;
`endif

   assign readAddress = addr;

`ifdef GAUS_SEQ_ABORT_EN
   // abort masks the strobe in the same cycle so no further request is accepted
   assign read = readReg & ~abort;
`else
   assign read = readReg;
`endif

   assign accept      = read & ~waitRequest;
   assign rspIn       = readDataValid & ((state == ISSUE) || (state == DRAIN));
   assign popBufferEn = rspIn;
   assign rspNext     = rspCount + CW'(rspIn);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         addr        <= START_A;
         reqCount    <= '0;
         rspCount    <= '0;
         gapCount    <= '0;
         atEnd       <= 1'b0;
         readReg     <= 1'b0;
         windowValid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef GAUS_SEQ_ABORT_EN
         aborting    <= 1'b0;
`endif
      end else begin
         if (rspIn) rspCount <= rspNext;

         unique case (state)
            IDLE: begin
               if (start) begin
                  addr     <= START_A;
                  reqCount <= '0;
                  rspCount <= '0;
                  atEnd    <= 1'b0;
                  readReg  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
`ifdef GAUS_SEQ_ABORT_EN
                  aborting <= 1'b0;
`endif
               end
            end

            ISSUE: begin
               if (accept) begin
                  reqCount <= reqCount + 1'b1;
                  atEnd    <= (addr == END_A);
                  // hold at ENDADDRESS so the address never wraps
                  if (addr != END_A) addr <= addr + 1'b1;
                  if (reqCount == REQ_LAST) begin
                     readReg <= 1'b0;
                     state   <= DRAIN;
                  end
               end
`ifdef GAUS_SEQ_ABORT_EN
               if (abort) begin
                  readReg <= 1'b0;
                  if (rspNext == reqCount) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     aborting <= 1'b1;
                     state    <= DRAIN;
                  end
               end
`endif
            end

            DRAIN: begin
               if (rspNext == BEATS_C) begin
                  windowValid <= 1'b1;
                  state       <= HOLD;
               end
`ifdef GAUS_SEQ_ABORT_EN
               // an aborted burst only waits for responses already requested
               if (aborting || abort) begin
                  windowValid <= 1'b0;
                  aborting    <= 1'b1;
                  state       <= DRAIN;
                  if (rspNext == reqCount) begin
                     aborting <= 1'b0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
               end
`endif
            end

            HOLD: begin
               if (windowReady) begin
                  windowValid <= 1'b0;
                  reqCount    <= '0;
                  rspCount    <= '0;
                  if (atEnd) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else if (PAUSE == 0) begin
                     readReg <= 1'b1;
                     state   <= ISSUE;
                  end else begin
                     gapCount <= '0;
                     state    <= GAP;
                  end
               end
`ifdef GAUS_SEQ_ABORT_EN
               if (abort) begin
                  windowValid <= 1'b0;
                  done        <= 1'b0;
                  readReg     <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
`endif
            end

            GAP: begin
               if (gapCount == GAP_LAST) begin
                  readReg <= 1'b1;
                  state   <= ISSUE;
               end else begin
                  gapCount <= gapCount + 1'b1;
               end
`ifdef GAUS_SEQ_ABORT_EN
               if (abort) begin
                  readReg <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
`endif
            end

            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gaus_read_sequencer.sv
// Directed bench for gaus_read_sequencer: instance A (BEATS=4, PAUSE=1,
// words 0..7) and instance B (BEATS=1, PAUSE=0, words 0..2).
module tb_gaus_read_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset = 1'b1;
   logic start = 1'b0;
   logic wr    = 1'b0;
   logic rdv   = 1'b0;
   logic rdy   = 1'b1;
   logic selB  = 1'b0;

   logic        startA, startB;
   logic [23:0] addrA, addrB;
   logic        readA, readB, popA, popB, wvA, wvB, busyA, busyB, doneA, doneB;
   logic [23:0] addrO;
   logic        readO, popO, wvO, busyO, doneO;
`ifdef GAUS_SEQ_ABORT_EN
   logic        abortA = 1'b0;
`endif

   assign startA = start & ~selB;
   assign startB = start & selB;
   assign addrO  = selB ? addrB : addrA;
   assign readO  = selB ? readB : readA;
   assign popO   = selB ? popB  : popA;
   assign wvO    = selB ? wvB   : wvA;
   assign busyO  = selB ? busyB : busyA;
   assign doneO  = selB ? doneB : doneA;

   gaus_read_sequencer #(.STARTADDRESS(0), .ENDADDRESS(7), .BEATS(4), .PAUSE(1), .ADDRW(24)) dutA (
      .clk(clk), .reset(reset), .start(startA), .readAddress(addrA), .read(readA),
      .waitRequest(wr), .readDataValid(rdv), .popBufferEn(popA), .windowValid(wvA),
      .windowReady(rdy), .busy(busyA), .done(doneA)
`ifdef GAUS_SEQ_ABORT_EN
      , .abort(abortA)
`endif
   );

   gaus_read_sequencer #(.STARTADDRESS(0), .ENDADDRESS(2), .BEATS(1), .PAUSE(0), .ADDRW(24)) dutB (
      .clk(clk), .reset(reset), .start(startB), .readAddress(addrB), .read(readB),
      .waitRequest(wr), .readDataValid(rdv), .popBufferEn(popB), .windowValid(wvB),
      .windowReady(rdy), .busy(busyB), .done(doneB)
`ifdef GAUS_SEQ_ABORT_EN
      , .abort(1'b0)
`endif
   );

   typedef struct packed {
      logic        s;
      logic        rdv;
      logic        eRead;
      logic [23:0] eAddr;
      logic        ePop;
      logic        eWv;
      logic        eBusy;
      logic        eDone;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic s, input logic r, input logic er, input int ea,
                               input logic ep, input logic ew, input logic eb, input logic ed);
      vec_t v;
      v.s = s; v.rdv = r; v.eRead = er; v.eAddr = 24'(ea);
      v.ePop = ep; v.eWv = ew; v.eBusy = eb; v.eDone = ed;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // applies tbl cycle by cycle; readAddress compared only while read is expected
   task automatic runTable(input string tag, output int pops, output int wvs);
      pops = 0;
      wvs  = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         start = tbl[i].s;
         rdv   = tbl[i].rdv;
         @(negedge clk);
         chk({tag, ".read"}, i, 32'(readO), 32'(tbl[i].eRead));
         if (tbl[i].eRead) chk({tag, ".addr"}, i, 32'(addrO), 32'(tbl[i].eAddr));
         chk({tag, ".pop"},  i, 32'(popO),  32'(tbl[i].ePop));
         chk({tag, ".wv"},   i, 32'(wvO),   32'(tbl[i].eWv));
         chk({tag, ".busy"}, i, 32'(busyO), 32'(tbl[i].eBusy));
         chk({tag, ".done"}, i, 32'(doneO), 32'(tbl[i].eDone));
         if (popO) pops++;
         if (wvO)  wvs++;
         cyc();
      end
      start = 1'b0;
      rdv   = 1'b0;
      tbl.delete();
   endtask

   initial begin
      int pops, wvs, acc;

      // reset state
      reset = 1'b1;
      cyc(); cyc();
      @(negedge clk);
      chk("rst.read", 0, 32'(readA), 0);
      chk("rst.addr", 0, 32'(addrA), 0);
      chk("rst.pop",  0, 32'(popA),  0);
      chk("rst.wv",   0, 32'(wvA),   0);
      chk("rst.busy", 0, 32'(busyA), 0);
      chk("rst.done", 0, 32'(doneA), 0);
      chk("rst.busyB", 0, 32'(busyB), 0);
      cyc();
      reset = 1'b0;

      // 8-word frame, responses two cycles after each accept
      //              s  rdv rd addr pop wv busy done
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 2, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 3, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 4, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 1, 5, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 6, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 7, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
      runTable("frameA", pops, wvs);
      chk("frameA.popTotal", 0, 32'(pops), 8);
      chk("frameA.wvTotal",  0, 32'(wvs),  2);

      // waitRequest stall on the second request, drain two, reset with two outstanding
      start = 1'b1;
      cyc();
      start = 1'b0;
      acc = 0;
      for (int c = 1; c <= 9; c++) begin
         wr  = (c >= 2 && c <= 4);
         rdv = (c >= 8);
         @(negedge clk);
         if (c >= 2 && c <= 5) begin
            chk("stall.read", c, 32'(readA), 1);
            chk("stall.addr", c, 32'(addrA), 1);
         end
         if (c >= 8) chk("stall.pop", c, 32'(popA), 1);
         if (readA && !wr) acc++;
         cyc();
      end
      wr  = 1'b0;
      rdv = 1'b0;
      chk("stall.accepts", 0, 32'(acc), 4);

      reset = 1'b1;
      cyc();
      reset = 1'b0;
      rdv   = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("abortRst.read", c, 32'(readA), 0);
         chk("abortRst.pop",  c, 32'(popA),  0);
         chk("abortRst.wv",   c, 32'(wvA),   0);
         chk("abortRst.busy", c, 32'(busyA), 0);
         chk("abortRst.done", c, 32'(doneA), 0);
         chk("abortRst.addr", c, 32'(addrA), 0);
         cyc();
      end
      rdv = 1'b0;

      // restart from address 0, then hold windowReady low for 5 cycles in HOLD
      rdy   = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 1; c <= 13; c++) begin
         rdv = (c >= 3 && c <= 6);
         rdy = (c >= 12);
         @(negedge clk);
         chk("hold.read", c, 32'(readA), 32'(c <= 4));
         if (c <= 4) chk("hold.addr", c, 32'(addrA), 32'(c - 1));
         chk("hold.wv", c, 32'(wvA), 32'(c >= 7 && c <= 12));
         cyc();
      end
      rdv   = 1'b0;
      rdy   = 1'b1;
      reset = 1'b1;
      cyc();
      reset = 1'b0;

      // PAUSE=0, BEATS=1: read returns one cycle after each handshake
      selB = 1'b1;
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 2, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      runTable("frameB", pops, wvs);
      chk("frameB.popTotal", 0, 32'(pops), 3);
      chk("frameB.wvTotal",  0, 32'(wvs),  3);
      selB = 1'b0;

`ifdef GAUS_SEQ_ABORT_EN
      // abort after two accepts: both words still pop, no window, no done
      begin
         int late, ab_pops, dones, wvSeen;
         late = 0; ab_pops = 0; dones = 0; wvSeen = 0; acc = 0;
         start = 1'b1;
         cyc();
         start = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            abortA = (c == 3);
            rdv    = (c == 3 || c == 4);
            @(negedge clk);
            if (c == 3) chk("abort.read", c, 32'(readA), 0);
            if (readA && !wr) begin
               if (c <= 2) acc++;
               else late++;
            end
            if (popA)  ab_pops++;
            if (doneA) dones++;
            if (wvA)   wvSeen++;
            cyc();
         end
         abortA = 1'b0;
         rdv    = 1'b0;
         chk("abort.accepts",  0, 32'(acc),     2);
         chk("abort.lateReqs", 0, 32'(late),    0);
         chk("abort.pops",     0, 32'(ab_pops), 2);
         chk("abort.done",     0, 32'(dones),   0);
         chk("abort.wv",       0, 32'(wvSeen),  0);
         @(negedge clk);
         chk("abort.idle", 0, 32'(busyA), 0);
         cyc();
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
